// File: rtl/xor_stream_driver.sv
`default_nettype none
// ============================================================================
//  Module   : xor_stream_driver
//  Purpose  : Self-test master for the 2-in/1-out XOR stream pipeline. It
//             sends LFSR operand pairs and checks each returned XOR result.
//  Revision : 1.0  initial release
// ============================================================================
module xor_stream_driver #(
  parameter int         NUM_TXN   = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         EXP_DEPTH = 8,
  parameter int         TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] din,
  output logic       wr_en,
  input  logic       full,
  input  logic       res,
  input  logic       res_valid,
  output logic       res_rd,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] txn_count
);

  localparam int               c_aw       = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam logic [c_aw:0]    c_depth    = EXP_DEPTH[c_aw:0];
  localparam logic [c_aw:0]    c_cnt_one  = 1;
  localparam logic [c_aw-1:0]  c_ptr_one  = 1;
  localparam logic [7:0]       c_num      = 8'(NUM_TXN);
  localparam logic [7:0]       c_tmo_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [7:0]           r_sent;
  logic [7:0]           r_txn;
  logic [7:0]           r_err;
  logic [7:0]           r_tmo;
  logic [EXP_DEPTH-1:0] r_q;
  logic [c_aw-1:0]      r_wptr;
  logic [c_aw-1:0]      r_rptr;
  logic [c_aw:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;

  logic       w_q_empty;
  logic       w_q_full;
  logic       w_pop_hit;
  logic       w_spur;
  logic       w_err_inc;
  logic       w_tmo_fire;
  logic [7:0] w_lfsr_nxt;
  logic [7:0] w_err_add;
  logic [8:0] w_err_sum;
  logic [7:0] w_err_nxt;

  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign din        = r_lfsr[1:0];

  assign w_q_empty = (r_cnt == '0);
  assign w_q_full  = (r_cnt == c_depth);

  assign wr_en  = (r_state == S_SEND) && !full && (r_sent < c_num) && !w_q_full;
  assign res_rd = res_valid && ((r_state == S_SEND) || (r_state == S_DRAIN));

  // Emptiness is judged before this cycle's push: a result can never pair with
  // an operand issued in the same cycle.
  assign w_pop_hit  = res_rd && !w_q_empty;
  assign w_spur     = res_rd && w_q_empty;
  assign w_err_inc  = w_spur || (w_pop_hit && (res != r_q[r_rptr]));
  assign w_tmo_fire = (r_state == S_DRAIN) && !res_rd && (r_tmo == c_tmo_last);

  assign w_err_add = w_tmo_fire ? (c_num - r_txn) : {7'd0, w_err_inc};
  assign w_err_sum = {1'b0, r_err} + {1'b0, w_err_add};
  assign w_err_nxt = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_sent  <= 8'd0;
      r_txn   <= 8'd0;
      r_err   <= 8'd0;
      r_tmo   <= 8'd0;
      r_q     <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      if (wr_en) begin
        r_q[r_wptr] <= din[1] ^ din[0];
        r_wptr      <= r_wptr + c_ptr_one;
        r_lfsr      <= w_lfsr_nxt;
        r_sent      <= r_sent + 8'd1;
      end
      if (w_pop_hit) begin
        r_rptr <= r_rptr + c_ptr_one;
        r_txn  <= r_txn + 8'd1;
      end
      case ({wr_en, w_pop_hit})
        2'b10:   r_cnt <= r_cnt + c_cnt_one;
        2'b01:   r_cnt <= r_cnt - c_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
      r_err <= w_err_nxt;
      r_tmo <= ((r_state == S_DRAIN) && !res_rd) ? r_tmo + 8'd1 : 8'd0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_SEND;
            r_lfsr  <= LFSR_SEED;
            r_sent  <= 8'd0;
            r_txn   <= 8'd0;
            r_err   <= 8'd0;
            r_tmo   <= 8'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_SEND: begin
          if (r_sent == c_num) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_txn == c_num) || w_tmo_fire) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 8'd0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign txn_count = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_stream_driver
//  Purpose  : Randomised bench for xor_stream_driver with a 2-cycle XOR
//             pipeline model and a transaction-level reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xor_stream_driver;

  localparam int NUM_TXN   = 16;
  localparam int EXP_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       full = 1'b0;
  logic       res = 1'b0;
  logic       res_valid = 1'b0;
  logic [1:0] din;
  logic       wr_en;
  logic       res_rd;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] txn_count;

  xor_stream_driver #(
    .NUM_TXN  (NUM_TXN),
    .LFSR_SEED(8'hA5),
    .EXP_DEPTH(EXP_DEPTH),
    .TIMEOUT  (255)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .wr_en    (wr_en),
    .full     (full),
    .res      (res),
    .res_valid(res_valid),
    .res_rd   (res_rd),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic val;
    int   ready;
  } pres_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    n_sent = 0;
  int    n_txn = 0;
  bit    started = 1'b0;
  bit    idle_phase = 1'b1;
  bit    pend_start = 1'b0;
  bit    force_full = 1'b0;
  bit    inject = 1'b0;
  bit    from_pipe = 1'b0;
  int    full_pct = 0;
  int    stall_pct = 0;
  int    corrupt_idx = -1;
  int    drop_idx = -1;
  pres_t pipe[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // n-th value of the operand generator counting from the seed
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic step();
    int         occ;
    logic [7:0] lv;
    @(negedge clk);
    cyc++;
    start = pend_start;
    pend_start = 1'b0;
    full = force_full ? 1'b1 : ($urandom_range(99) < full_pct);
    from_pipe = 1'b0;
    if (inject) begin
      res_valid = 1'b1;
      res = 1'($urandom_range(1));
      inject = 1'b0;
    end else if (pipe.size() > 0 && pipe[0].ready <= cyc && $urandom_range(99) >= stall_pct) begin
      res_valid = 1'b1;
      res = pipe[0].val;
      from_pipe = 1'b1;
    end else begin
      res_valid = 1'b0;
      res = 1'b0;
    end
    #1;
    occ = n_sent - n_txn;
    lv = lfsr_at(n_sent);
    check_val("din", 32'(din), 32'(lv[1:0]));
    check_val("wr_en", 32'(wr_en),
              32'(started && !full && n_sent < NUM_TXN && occ < EXP_DEPTH));
    check_val("res_rd", 32'(res_rd), 32'(res_valid && !idle_phase));
    if (wr_en) begin
      if (n_sent != drop_idx)
        pipe.push_back('{val: (lv[1] ^ lv[0]) ^ (n_sent == corrupt_idx), ready: cyc + 2});
      n_sent++;
    end
    if (res_rd) begin
      if (from_pipe) void'(pipe.pop_front());
      if (occ != 0) n_txn++;
    end
    if (rst && start) begin
      started = 1'b1;
      idle_phase = 1'b0;
      n_sent = 0;
      n_txn = 0;
      pipe.delete();
    end
  endtask

  task automatic do_run(input string tag, input int corrupt, input int drop,
                        input int fpct, input int spct, input bit spur, input bit bp);
    int exp_err;
    int exp_txn;
    bit got;
    corrupt_idx = corrupt;
    drop_idx = drop;
    full_pct = fpct;
    stall_pct = spct;
    exp_err = (corrupt >= 0 ? 1 : 0) + (drop >= 0 ? 1 : 0) + (spur ? 1 : 0);
    exp_txn = NUM_TXN - (drop >= 0 ? 1 : 0);
    force_full = spur;
    pend_start = 1'b1;
    step();
    step();
    check_val({tag, "_busy0"}, 32'(busy), 32'd1);
    check_val({tag, "_clr"}, {22'd0, done, pass, err_count}, 32'd0);
    if (spur) begin
      inject = 1'b1;
      step();
      force_full = 1'b0;
    end
    if (bp) begin
      repeat (4) step();
      force_full = 1'b1;
      repeat (10) step();
      force_full = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      step();
      got = done;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_err"}, 32'(err_count), 32'(exp_err));
    check_val({tag, "_txn"}, 32'(txn_count), 32'(exp_txn));
    check_val({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
    idle_phase = 1'b1;
    inject = 1'b1;
    step();
    check_val({tag, "_hold_err"}, 32'(err_count), 32'(exp_err));
    check_val({tag, "_hold_txn"}, 32'(txn_count), 32'(exp_txn));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      pend_start = (i % 2 == 0);
      step();
      check_val("rst_outs", {17'd0, wr_en, res_rd, busy, done, pass, err_count, txn_count[1:0]}, 32'd0);
      check_val("rst_txn", 32'(txn_count), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    check_val("post_rst_din", 32'(din), 32'd1);

    do_run("normal", -1, -1, 0, 0, 1'b0, 1'b0);
    do_run("bp", -1, -1, 30, 20, 1'b0, 1'b1);
    do_run("corrupt", 2, -1, 0, 0, 1'b0, 1'b0);
    do_run("drop", -1, NUM_TXN - 1, 0, 0, 1'b0, 1'b0);
    do_run("spur", -1, -1, 0, 0, 1'b1, 1'b0);

    // reset in the middle of SEND, then a clean run
    corrupt_idx = -1;
    drop_idx = -1;
    full_pct = 0;
    stall_pct = 0;
    pend_start = 1'b1;
    repeat (6) step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("mid_rst_outs", {19'd0, busy, done, pass, err_count, txn_count[2:0]}, 32'd0);
    check_val("mid_rst_txn", 32'(txn_count), 32'd0);
    check_val("mid_rst_din", 32'(din), 32'd1);
    started = 1'b0;
    idle_phase = 1'b1;
    n_sent = 0;
    n_txn = 0;
    pipe.delete();
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    step();
    do_run("after_rst", -1, -1, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      do_run("rand", ($urandom_range(1) == 1) ? int'($urandom_range(NUM_TXN - 1)) : -1, -1,
             int'($urandom_range(50)), int'($urandom_range(30)), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
